// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control path: state encoding, opcodes, datapath select codes.
// Pure declarations; no latency or backpressure of its own.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_SHIMM = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that hold while the unified memory has not completed the access.
   function automatic logic is_wait_state(input state_t s);
      return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
   endfunction

endpackage

// File: rtl/ctrl_state_decode.sv
// Combinational map from FSM state (+ mem_ready, timeout, bne flag) to datapath strobes and selects.
// Zero latency; strobes in wait states follow mem_ready, and everything is forced low while reset is high.
module ctrl_state_decode
   import cpu_ctrl_pkg::*;
(
   input  logic       reset,
   input  state_t     state,
   input  logic       mem_ready,
   input  logic       bne_op,
   input  logic       timeout,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsource,
   output logic [1:0] aluop,
   output logic       branch_ne,
   output logic       illegal,
   output logic       bus_error
);

   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = SRCB_B;
      pcsource    = PCSRC_ALU;
      aluop       = ALUOP_ADD;
      branch_ne   = 1'b0;
      illegal     = 1'b0;
      bus_error   = 1'b0;
      if (!reset) begin
         bus_error = timeout;
         branch_ne = (state == BRANCH) && bne_op;
         case (state)
            FETCH: begin
               // IR and PC only latch once the fetch actually completes.
               memread = 1'b1;
               alusrcb = SRCB_FOUR;
               irwrite = mem_ready;
               pcwrite = mem_ready;
            end
            DECODE: alusrcb = SRCB_SHIMM;
            MEMADR, ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = SRCB_IMM;
            end
            MEMRD: begin
               memread = 1'b1;
               iord    = 1'b1;
            end
            MEMWB: begin
               memtoreg = 1'b1;
               regwrite = 1'b1;
            end
            MEMWR: begin
               memwrite = 1'b1;
               iord     = 1'b1;
            end
            EXEC: begin
               alusrca = 1'b1;
               aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
               regdst   = 1'b1;
               regwrite = 1'b1;
            end
            ADDIWB: regwrite = 1'b1;
            BRANCH: begin
               alusrca     = 1'b1;
               aluop       = ALUOP_SUB;
               pcwritecond = 1'b1;
               pcsource    = PCSRC_ALUOUT;
            end
            JUMP: begin
               pcwrite  = 1'b1;
               pcsource = PCSRC_JUMP;
            end
            TRAP: illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait/timeout and retired counter; bne support under `BNE_EN.
// 3-5 cycles per instruction plus one per mem_ready-low cycle in FETCH/MEMRD/MEMWR; timeout abandons to FETCH.
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int RET_W      = 32,
   parameter int TMO_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwritecond,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regdst,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       pcsource,
   output logic [1:0]       aluop,
   output logic             branch_ne,
   output logic             illegal,
   output logic             bus_error,
   output logic [RET_W-1:0] retired
);

   localparam int WAIT_W = (TMO_CYCLES < 2) ? 1 : $clog2(TMO_CYCLES + 1);
   localparam logic [WAIT_W-1:0] TMO_VAL = WAIT_W'(TMO_CYCLES);

   state_t            state;
   state_t            state_nxt;
   logic [5:0]        op_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              in_wait;
   logic              timeout;
   logic              retire;
   logic              bne_op;

   assign in_wait = is_wait_state(state);
   assign timeout = (TMO_CYCLES != 0) && in_wait && !mem_ready && (wait_cnt == TMO_VAL);

`ifdef BNE_EN
   assign bne_op = (op_q == OP_BNE);
`else
   assign bne_op = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         FETCH: begin
            if (timeout)        state_nxt = FETCH;
            else if (mem_ready) state_nxt = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_RTYPE:     state_nxt = EXEC;
               OP_ADDI:      state_nxt = ADDIEX;
               OP_BEQ:       state_nxt = BRANCH;
`ifdef BNE_EN
               OP_BNE:       state_nxt = BRANCH;
`endif
               OP_J:         state_nxt = JUMP;
               default:      state_nxt = TRAP;
            endcase
         end
         MEMADR: state_nxt = (op_q == OP_LW) ? MEMRD : MEMWR;
         MEMRD: begin
            if (timeout)        state_nxt = FETCH;
            else if (mem_ready) state_nxt = MEMWB;
         end
         MEMWR: begin
            // A completed store retires; an abandoned one does not.
            if (timeout || mem_ready) state_nxt = FETCH;
            retire = mem_ready;
         end
         EXEC:   state_nxt = ALUWB;
         ADDIEX: state_nxt = ADDIWB;
         MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
            state_nxt = FETCH;
            retire    = 1'b1;
         end
         TRAP:    state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         op_q     <= '0;
         wait_cnt <= '0;
         retired  <= '0;
      end else begin
         state <= state_nxt;
         if (state == DECODE) op_q <= opcode;
         // Re-entering FETCH after a timeout counts as a fresh entry.
         if (timeout || (state_nxt != state))
            wait_cnt <= '0;
         else if (in_wait && !mem_ready && (wait_cnt != TMO_VAL))
            wait_cnt <= wait_cnt + WAIT_W'(1);
         if (retire) retired <= retired + RET_W'(1);
      end
   end

   ctrl_state_decode u_decode (
      .reset       (reset),
      .state       (state),
      .mem_ready   (mem_ready),
      .bne_op      (bne_op),
      .timeout     (timeout),
      .pcwrite     (pcwrite),
      .pcwritecond (pcwritecond),
      .iord        (iord),
      .memread     (memread),
      .memwrite    (memwrite),
      .irwrite     (irwrite),
      .memtoreg    (memtoreg),
      .regdst      (regdst),
      .regwrite    (regwrite),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .pcsource    (pcsource),
      .aluop       (aluop),
      .branch_ne   (branch_ne),
      .illegal     (illegal),
      .bus_error   (bus_error)
   );

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle main decoder. A Moore state machine sequences each MIPS instruction (lw, sw, beq, j, addi, R-type) over 3–5 cycles on a shared ALU and unified memory. It stalls on a memory-ready handshake, flags illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register's opcode field and the multi-cycle datapath's mux selects and write enables.

## Interface
- RET_W, 32, width of the retired-instruction counter.
- TMO_CYCLES, 16, number of consecutive mem_ready-low cycles in a wait state before a bus error is raised; 0 disables the timeout.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset; synchronous and active-high.
- opcode  input  6  instruction[31:26], sampled only in DECODE.
- mem_ready  input  1  memory completes the current access this cycle.
- pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca  output  1 each  datapath strobes and selects.
- alusrcb  output  2  encoding: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- pcsource  output  2  encoding: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- aluop  output  2  encoding: 00 = add, 01 = subtract, 10 = funct-decoded.
- branch_ne  output  1  datapath branches on !zero instead of zero.
- illegal  output  1  one-cycle pulse for an unsupported opcode.
- bus_error  output  1  one-cycle pulse on memory timeout.
- retired  output  RET_W  count of completed instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP.
- Outputs are a pure decode of the state, plus mem_ready where noted. Any output not listed for a state is 0.
  - FETCH: memread=1, alusrcb=01, irwrite=pcwrite=mem_ready.
  - DECODE: alusrcb=11.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10.
  - MEMRD: memread=1, iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: memwrite=1, iord=1.
  - EXEC: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JUMP: pcwrite=1, pcsource=10.
  - TRAP: illegal=1.
- Transitions:
  - FETCH→DECODE on mem_ready.
  - DECODE branches by opcode: 100011/101011→MEMADR; 000000→EXEC; 001000→ADDIEX; 000100→BRANCH; 000010→JUMP; anything else→TRAP.
  - MEMADR→MEMRD for lw, MEMADR→MEMWR for sw, using the opcode latched in DECODE.
  - MEMRD→MEMWB on mem_ready; MEMWR→FETCH on mem_ready.
  - EXEC→ALUWB, ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, TRAP→FETCH.
- Wait states are FETCH, MEMRD and MEMWR. The state is held and its strobes stay asserted while mem_ready=0.
- Timeout:
  - A wait counter clears on entry to a wait state and increments each cycle mem_ready=0.
  - When the counter equals TMO_CYCLES and mem_ready is still 0, bus_error pulses, the access is abandoned and the next state is FETCH.
  - A timed-out FETCH does not write the PC.
- retired increments by 1 in the cycle leaving MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP. It wraps from 2^RET_W−1 to 0. TRAP and timeouts do not count.

## Timing
- Reset: state=FETCH, retired=0, wait counter=0, latched opcode=0.
- While reset=1, every strobe is forced to 0: pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite, illegal and bus_error. Selects are 0.
- Reset mid-instruction aborts it with no further writes.
- Cycles with zero wait states: lw 5; sw, R-type and addi 4; beq and j 3; illegal 3 (FETCH, DECODE, TRAP).
- Each cycle of mem_ready=0 adds one cycle. mem_ready is ignored outside wait states.

## Configuration
- BNE_EN defined: opcode 000101 decodes to BRANCH with branch_ne=1, and branch_ne=0 for beq.
- BNE_EN undefined: 000101 goes to TRAP, and branch_ne is tied to 0.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state enum;
  - opcode localparams (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_RTYPE);
  - aluop, alusrcb and pcsource encodings.
- One combinational sub-module, ctrl_state_decode, maps state, mem_ready and the latched opcode to all output strobes. The top level keeps the state register, the wait counter and the retired counter.

## Test plan
- Reset held 3 cycles with mem_ready=1 → all strobes 0 and retired=0. First cycle after release: memread=1, alusrcb=01, pcwrite=1.
- lw (100011) with mem_ready=1 throughout → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; memtoreg=regwrite=1 in cycle 5; retired=1.
- sw with mem_ready low for 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles, total 7 cycles, exactly one retired increment.
- Opcode 111111 → illegal pulses once in cycle 3, back in FETCH on cycle 4, retired unchanged.
- TMO_CYCLES=4, mem_ready stuck low in FETCH → bus_error in the 5th FETCH cycle, pcwrite never asserted, FETCH re-entered.
- BNE_EN defined, opcode 000101 → BRANCH with branch_ne=1, pcwritecond=1, aluop=01. Without BNE_EN → TRAP. retired preset to 2^RET_W−1, then a j → retired wraps to 0.
